// File: rtl/serial_w_driver_pkg.sv
// serial_w_driver_pkg
//   Shared constants for the serial w-line driver and its bit-rate divider:
//   FSM state encodings, the idle level of w, and a constant clog2 helper.
//   No ports (package).
package serial_w_driver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Level held on w between patterns so the downstream detector settles.
  localparam logic W_IDLE = 1'b0;

  // Ceiling log2, usable in constant expressions (clog2(1) == 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_w_driver_tick_div.sv
// bit_tick_div
//   Bit-rate divider: counts enabled cycles modulo BIT_DIV and flags the
//   terminal count. Reusable by any later bit-rate stage.
// Ports:
//   Clock  - system clock, rising edge
//   Resetn - asynchronous active-low reset
//   clr    - synchronous clear of the count (wins over en)
//   en     - advance the count this cycle
//   tick   - high when en is set and the count is at BIT_DIV-1
module bit_tick_div
  import serial_w_driver_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (BIT_DIV > 1) ? clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BIT_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          term_s;

  // With BIT_DIV=1 TERM is zero and the count never leaves zero, so tick == en.
  assign term_s = (cnt_q == TERM);
  assign tick   = en & term_s;

  // Next count: clear, wrap at terminal, or advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (term_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_w_driver.sv
// serial_w_driver
//   Loads a parallel pattern word and serialises it MSB-first onto w, each
//   bit held BIT_DIV clocks, with a busy/done handshake. w idles low.
//   Optional feature macro SERIAL_W_PARITY_EN: appends one even-parity bit
//   (XOR of the captured word) after the data bits.
// Ports:
//   Clock  - system clock, rising edge
//   Resetn - asynchronous active-low reset
//   start  - launch request, honoured only in IDLE without abort
//   abort  - synchronous cancel of an in-progress pattern
//   data   - pattern word, captured on an accepted start
//   w      - serial bit to the downstream detector (registered)
//   busy   - high while bits are being driven (registered)
//   done   - one-cycle pulse after the last bit (registered)
//   st     - current state encoding for debug
module serial_w_driver
  import serial_w_driver_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BIT_DIV = 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [1:0]       st
);

`ifdef SERIAL_W_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int             BCW  = clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST = BCW'(NBITS - 1);

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             w_q, w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] load_s;
  logic             div_en_s;
  logic             div_clr_s;
  logic             tick_s;

`ifdef SERIAL_W_PARITY_EN
  assign load_s = {data, ^data};
`else
  assign load_s = data;
`endif

  // Divider runs only in SHIFT; any other state or an abort restarts it.
  assign div_en_s  = (state_q == ST_SHIFT);
  assign div_clr_s = (state_q != ST_SHIFT) | abort;

  bit_tick_div #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (div_clr_s),
    .en     (div_en_s),
    .tick   (tick_s)
  );

  // FSM next state, shift register and bit counter.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_SHIFT;
          shreg_d   = load_s;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else if (tick_s) begin
          if (bit_cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // start and abort are both ignored here; done always completes.
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it,
  // putting data[MSB] on w in the same cycle SHIFT is entered.
  always_comb begin
    w_d    = W_IDLE;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == ST_SHIFT) begin
      w_d    = shreg_d[NBITS-1];
      busy_d = 1'b1;
    end else if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      w_d = W_IDLE;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      w_q       <= W_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      w_q       <= w_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w    = w_q;
  assign busy = busy_q;
  assign done = done_q;
  assign st   = state_q;

endmodule

// File: tb/tb_serial_w_driver.sv
// tb_serial_w_driver
//   Directed bench for serial_w_driver: one instance with BIT_DIV=1 and one
//   with BIT_DIV=3. Expected {w,busy,done,st} per cycle is queued when a
//   pattern is launched and popped as each cycle is observed.
module tb_serial_w_driver;

`ifdef SERIAL_W_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       Clock;
  logic       Resetn;
  logic       start1, start3, abort1, abort3;
  logic [7:0] data;
  logic       w1, busy1, done1, w3, busy3, done3;
  logic [1:0] st1, st3;
  logic       sel;
  logic [4:0] obs;
  logic [4:0] sb[$];
  int         checks;
  int         errors;

  serial_w_driver #(.WIDTH(8), .BIT_DIV(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .start(start1), .abort(abort1),
    .data(data), .w(w1), .busy(busy1), .done(done1), .st(st1)
  );

  serial_w_driver #(.WIDTH(8), .BIT_DIV(3)) dut3 (
    .Clock(Clock), .Resetn(Resetn), .start(start3), .abort(abort3),
    .data(data), .w(w3), .busy(busy3), .done(done3), .st(st3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign obs = sel ? {w3, busy3, done3, st3} : {w1, busy1, done1, st1};

  localparam logic [4:0] R_IDLE = 5'b00000;
  localparam logic [4:0] R_DONE = 5'b00110;

  function automatic logic [NB-1:0] model_bits(input logic [7:0] d);
`ifdef SERIAL_W_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed={w,busy,done,st}=%b expected=%b", tag, o, e);
    end
  endtask

  // Launch a pattern on the selected instance and check every cycle until
  // two idle cycles after done. Optionally pulse start during the DONE cycle.
  task automatic run_pattern(input string tag, input bit use3, input logic [7:0] d,
                             input bit start_in_done);
    logic [NB-1:0] bits;
    logic [4:0]    e;
    int            div;
    int            k;
    div  = use3 ? 3 : 1;
    bits = model_bits(d);
    sel  = use3;
    for (int b = NB - 1; b >= 0; b--) begin
      for (int c = 0; c < div; c++) sb.push_back({bits[b], 1'b1, 1'b0, 2'b01});
    end
    sb.push_back(R_DONE);
    sb.push_back(R_IDLE);
    sb.push_back(R_IDLE);
    @(negedge Clock);
    data = d;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    k = 0;
    while (sb.size() > 0) begin
      @(negedge Clock);
      e = sb.pop_front();
      chk($sformatf("%s_cyc%0d", tag, k), obs, e);
      start1 = 1'b0;
      start3 = 1'b0;
      if (start_in_done && (k == NB * div)) begin
        if (use3) start3 = 1'b1; else start1 = 1'b1;
      end
      k++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    Resetn = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    abort1 = 1'b0; abort3 = 1'b0;
    data   = 8'h00;
    repeat (2) @(negedge Clock);
    sel = 1'b0; #1 chk("reset_d1", obs, R_IDLE);
    sel = 1'b1; #1 chk("reset_d3", obs, R_IDLE);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    sel = 1'b0; #1 chk("idle_after_reset", obs, R_IDLE);

    // Basic pattern, plus a start during DONE that must be ignored.
    run_pattern("d3_div1", 1'b0, 8'hD3, 1'b1);
    // Each bit held three cycles.
    run_pattern("a5_div3", 1'b1, 8'hA5, 1'b0);

    // Abort while bit_cnt==4; a mid-pattern start with new data is ignored.
    sel = 1'b0;
    for (int i = 0; i < 5; i++) sb.push_back({1'b1, 1'b1, 1'b0, 2'b01});
    for (int i = 0; i < 3; i++) sb.push_back(R_IDLE);
    @(negedge Clock);
    data   = 8'hFF;
    start1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [4:0] e;
      @(negedge Clock);
      e = sb.pop_front();
      chk($sformatf("abort_cyc%0d", k), obs, e);
      start1 = 1'b0;
      abort1 = 1'b0;
      if (k == 2) begin
        data   = 8'h00;
        start1 = 1'b1;
      end
      if (k == 4) abort1 = 1'b1;
    end

    // abort together with start in IDLE: no launch.
    start1 = 1'b1;
    abort1 = 1'b1;
    data   = 8'hFF;
    sb.push_back(R_IDLE);
    sb.push_back(R_IDLE);
    @(negedge Clock);
    chk("abort_beats_start0", obs, sb.pop_front());
    start1 = 1'b0;
    abort1 = 1'b0;
    @(negedge Clock);
    chk("abort_beats_start1", obs, sb.pop_front());

    // Asynchronous reset mid-bit, then a fresh pattern.
    @(negedge Clock);
    data   = 8'h81;
    start1 = 1'b1;
    @(negedge Clock);
    start1 = 1'b0;
    @(negedge Clock);
    chk("pre_async_reset", obs, {1'b0, 1'b1, 1'b0, 2'b01});
    #2 Resetn = 1'b0;
    #1 chk("async_reset", obs, R_IDLE);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    chk("after_async_reset", obs, R_IDLE);
    run_pattern("p81_div1", 1'b0, 8'h81, 1'b0);

    // Parity-sensitive words (ninth bit 1 for 07, 0 for 03 when enabled).
    run_pattern("p07_div1", 1'b0, 8'h07, 1'b0);
    run_pattern("p03_div3", 1'b1, 8'h03, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
